// File: rtl/latch_bus_reader_pkg.sv
// latch_reader_pkg -- shared state encoding and constants for latch_bus_reader.
// Rev 1.0
`default_nettype none

package latch_reader_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ENABLE  = 2'd1,
      CAPTURE = 2'd2,
      HOLD    = 2'd3
   } state_t;

   localparam int CNT_W = 4;

   // Word presented when the selected index has no latch behind it.
   localparam logic [63:0] FILL_ONES = '1;

   function automatic logic idx_in_range(input logic [3:0] idx, input int n);
      return ({1'b0, idx} < 5'(n));
   endfunction

endpackage

`default_nettype wire

// File: rtl/latch_bus_reader_capture_reg.sv
// capture_reg -- WIDTH-bit load-enabled register with asynchronous clear (74S174 style).
// Rev 1.0
`default_nettype none

module capture_reg #(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;

   always_comb begin
      data_d = data_q;
      if (load) begin
         data_d = d;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q = data_q;

endmodule

`default_nettype wire

// File: rtl/latch_bus_reader.sv
// latch_bus_reader -- one-at-a-time reader for a bank of tri-state latches on a shared bus.
// Rev 1.0. Optional parity check enabled by defining LATCH_BUS_PARITY_EN.
`default_nettype none

module latch_bus_reader
   import latch_reader_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NLATCH = 4,
   parameter int SETTLE = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req,
   input  logic [3:0]        sel,
   output logic              busy,
   output logic [NLATCH-1:0] oenb_n,
   input  logic [WIDTH-1:0]  bus_in,
   output logic [WIDTH-1:0]  data_out,
   output logic              valid,
   input  logic              ack
`ifdef LATCH_BUS_PARITY_EN
   ,
   input  logic              bus_par,
   output logic              par_err
`endif
);

   localparam logic [CNT_W-1:0] C_LAST = (SETTLE > 0) ? CNT_W'(SETTLE - 1) : '0;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         sel_q, sel_d;
   logic [NLATCH-1:0]  oenb_q, oenb_d;
   logic               load;
   logic               sel_ok;
   logic [WIDTH-1:0]   cap_word;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req) begin
               sel_d   = sel;
               cnt_d   = '0;
               state_d = (SETTLE > 0) ? ENABLE : CAPTURE;
            end
         end
         ENABLE: begin
            if (cnt_q == C_LAST) begin
               cnt_d   = '0;
               state_d = CAPTURE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         CAPTURE: begin
            load    = 1'b1;
            state_d = HOLD;
         end
         HOLD: begin
            if (ack) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Enables are decoded from next state so the pins come straight off flops.
      oenb_d = '1;
      if ((state_d == ENABLE || state_d == CAPTURE) && idx_in_range(sel_d, NLATCH)) begin
         for (int i = 0; i < NLATCH; i++) begin
            if (sel_d == 4'(i)) begin
               oenb_d[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         oenb_q  <= '1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         oenb_q  <= oenb_d;
      end
   end

   assign sel_ok   = idx_in_range(sel_q, NLATCH);
   assign cap_word = sel_ok ? bus_in : FILL_ONES[WIDTH-1:0];

   capture_reg #(.WIDTH(WIDTH)) u_data_reg (
      .clock (clock),
      .reset (reset),
      .load  (load),
      .d     (cap_word),
      .q     (data_out)
   );

`ifdef LATCH_BUS_PARITY_EN
   logic par_bad;
   logic par_q;

   // Odd parity: an even count of ones across bus_in and bus_par is an error.
   assign par_bad = sel_ok & ~(bus_par ^ (^bus_in));

   capture_reg #(.WIDTH(1)) u_par_reg (
      .clock (clock),
      .reset (reset),
      .load  (load),
      .d     (par_bad),
      .q     (par_q)
   );

   assign par_err = par_q & valid;
`endif

   assign oenb_n = oenb_q;
   assign busy   = (state_q != IDLE);
   assign valid  = (state_q == HOLD);

endmodule

`default_nettype wire

// File: tb/tb_latch_bus_reader.sv
// tb_latch_bus_reader -- directed checks of latch_bus_reader (NLATCH=4 and NLATCH=3 builds).
// Rev 1.0
`default_nettype none

module tb_latch_bus_reader;

   logic       clock;
   logic       reset;
   logic       req, ack;
   logic [3:0] sel;
   logic [7:0] bus_in;
   logic       busy, valid;
   logic [3:0] oenb_n;
   logic [7:0] data_out;

   logic       req3, ack3;
   logic [3:0] sel3;
   logic [7:0] bus3;
   logic       busy3, valid3;
   logic [2:0] oenb3;
   logic [7:0] data3;

`ifdef LATCH_BUS_PARITY_EN
   logic bus_par, par_err, bus_par3, par_err3;
`endif

   int total = 0;
   int bad   = 0;

   latch_bus_reader #(.WIDTH(8), .NLATCH(4), .SETTLE(2)) dut (
      .clock(clock), .reset(reset), .req(req), .sel(sel), .busy(busy),
      .oenb_n(oenb_n), .bus_in(bus_in), .data_out(data_out), .valid(valid), .ack(ack)
`ifdef LATCH_BUS_PARITY_EN
      , .bus_par(bus_par), .par_err(par_err)
`endif
   );

   latch_bus_reader #(.WIDTH(8), .NLATCH(3), .SETTLE(2)) dut3 (
      .clock(clock), .reset(reset), .req(req3), .sel(sel3), .busy(busy3),
      .oenb_n(oenb3), .bus_in(bus3), .data_out(data3), .valid(valid3), .ack(ack3)
`ifdef LATCH_BUS_PARITY_EN
      , .bus_par(bus_par3), .par_err(par_err3)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish, required finish before 200000");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   task automatic start_read(input logic [3:0] s, input logic [7:0] b);
      sel    = s;
      bus_in = b;
      req    = 1'b1;
      @(negedge clock);
      req    = 1'b0;
   endtask

   task automatic do_ack();
      ack = 1'b1;
      @(negedge clock);
      ack = 1'b0;
   endtask

   initial begin
      reset = 1'b1; req = 0; ack = 0; sel = 0; bus_in = 0;
      req3 = 0; ack3 = 0; sel3 = 0; bus3 = 0;
`ifdef LATCH_BUS_PARITY_EN
      bus_par = 0; bus_par3 = 0;
`endif
      #2;
      check("rst_oenb", 32'(oenb_n), 32'hF);
      check("rst_valid", 32'(valid), 0);
      check("rst_data", 32'(data_out), 0);
      check("rst_busy", 32'(busy), 0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);

      // Scenario 1: basic read
      start_read(4'd2, 8'hA5);
      check("s1_busy", 32'(busy), 1);
      for (int i = 0; i < 3; i++) begin
         check("s1_oenb_on", 32'(oenb_n), 32'hB);
         check("s1_valid_early", 32'(valid), 0);
         @(negedge clock);
      end
      check("s1_valid", 32'(valid), 1);
      check("s1_data", 32'(data_out), 32'hA5);
      check("s1_oenb_off", 32'(oenb_n), 32'hF);
      bus_in = 8'h00;
      @(negedge clock);
      check("s1_data_stable", 32'(data_out), 32'hA5);
      check("s1_oenb_hold", 32'(oenb_n), 32'hF);
      do_ack();
      check("s1_ack_valid", 32'(valid), 0);
      check("s1_ack_busy", 32'(busy), 0);

      // Scenario 2: back-to-back, req held high
      sel = 4'd0; bus_in = 8'h11; req = 1'b1;
      @(negedge clock);
      sel = 4'd1;
      for (int i = 0; i < 3; i++) begin
         check("s2_oenb0", 32'(oenb_n), 32'hE);
         @(negedge clock);
      end
      check("s2_valid0", 32'(valid), 1);
      check("s2_data0", 32'(data_out), 32'h11);
      bus_in = 8'h22;
      @(negedge clock);
      @(negedge clock);
      check("s2_req_ignored_valid", 32'(valid), 1);
      check("s2_req_ignored_oenb", 32'(oenb_n), 32'hF);
      check("s2_req_ignored_data", 32'(data_out), 32'h11);
      ack = 1'b1;
      @(negedge clock);
      ack = 1'b0;
      check("s2_gap_oenb", 32'(oenb_n), 32'hF);
      check("s2_gap_busy", 32'(busy), 0);
      @(negedge clock);
      req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("s2_oenb1", 32'(oenb_n), 32'hD);
         @(negedge clock);
      end
      check("s2_valid1", 32'(valid), 1);
      check("s2_data1", 32'(data_out), 32'h22);
      do_ack();

      // Scenario 3: reset during ENABLE
      start_read(4'd3, 8'h5A);
      check("s3_oenb_en", 32'(oenb_n), 32'h7);
      reset = 1'b1;
      #1;
      check("s3_rst_oenb", 32'(oenb_n), 32'hF);
      check("s3_rst_valid", 32'(valid), 0);
      check("s3_rst_data", 32'(data_out), 0);
      check("s3_rst_busy", 32'(busy), 0);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      start_read(4'd1, 8'h3C);
      for (int i = 0; i < 3; i++) begin
         check("s3_oenb", 32'(oenb_n), 32'hD);
         check("s3_valid_early", 32'(valid), 0);
         @(negedge clock);
      end
      check("s3_valid", 32'(valid), 1);
      check("s3_data", 32'(data_out), 32'h3C);

      // Scenario 5: long hold, then ack+req together
      bus_in = 8'h99;
      for (int i = 0; i < 10; i++) begin
         check("s5_hold_valid", 32'(valid), 1);
         check("s5_hold_data", 32'(data_out), 32'h3C);
         @(negedge clock);
      end
      ack = 1'b1; req = 1'b1;
      @(negedge clock);
      ack = 1'b0; req = 1'b0;
      check("s5_both_busy", 32'(busy), 0);
      check("s5_both_valid", 32'(valid), 0);
      @(negedge clock);
      check("s5_no_new_read", 32'(busy), 0);
      check("s5_no_new_oenb", 32'(oenb_n), 32'hF);

      // Scenario 4: out-of-range index on the NLATCH=3 build
      sel3 = 4'd3; bus3 = 8'h00; req3 = 1'b1;
      @(negedge clock);
      req3 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("s4_oenb", 32'(oenb3), 32'h7);
         check("s4_busy", 32'(busy3), 1);
         check("s4_valid_early", 32'(valid3), 0);
         @(negedge clock);
      end
      check("s4_valid", 32'(valid3), 1);
      check("s4_data", 32'(data3), 32'hFF);
      check("s4_oenb_hold", 32'(oenb3), 32'h7);
`ifdef LATCH_BUS_PARITY_EN
      check("s4_par", 32'(par_err3), 0);
`endif
      ack3 = 1'b1;
      @(negedge clock);
      ack3 = 1'b0;
      check("s4_ack_valid", 32'(valid3), 0);

`ifdef LATCH_BUS_PARITY_EN
      // Scenario 6: parity
      bus_par = 1'b0;
      start_read(4'd0, 8'h01);
      repeat (3) @(negedge clock);
      check("s6_valid_a", 32'(valid), 1);
      check("s6_par_ok", 32'(par_err), 0);
      do_ack();
      start_read(4'd2, 8'h03);
      repeat (3) @(negedge clock);
      check("s6_valid_b", 32'(valid), 1);
      check("s6_par_bad", 32'(par_err), 1);
      do_ack();
      check("s6_par_clr", 32'(par_err), 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
